bcd_down_timer: RTL
===================

Name: bcd_down_timer

Overview:
- Multi-digit BCD down-counter (countdown timer) with load, start, stop and terminal-count signalling.
- Counts in the opposite direction to the existing BCD up-counter chain and consumes the same single-cycle `tick` enable style.
- Used by the display and timer exercises for preset countdowns, e.g. a 4-digit seconds timer driven by a 1 Hz tick.

Parameters:
- NDIG, 4, number of BCD digits; q width is 4*NDIG.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- tick  input  1  count enable pulse; one decrement per cycle with tick=1 while RUN.
- load  input  1  load preset from load_val.
- load_val  input  4*NDIG  BCD preset; digit i is bits [4i+3:4i].
- start  input  1  begin or resume counting.
- stop  input  1  pause counting.
- q  output  4*NDIG  current BCD count, registered.
- busy  output  1  high while state is RUN, combinational from state.
- zero  output  1  high when q is all zero, combinational.
- done  output  1  one-cycle registered pulse on reaching terminal count.

Behaviour:
- Interface: one clock, `clk`; reset `rst` is asynchronous and active-high.
- Reset values: q=0, preset register=0, state=IDLE, done=0. Consequently busy=0 and zero=1.
- States: IDLE, RUN, PAUSE, DONE (2-bit encoding).
- Per-cycle priority, highest first: load > stop > start > tick.
- load (any state):
  - q <= load_val, and the preset register captures the same value.
  - Any digit >9 is clamped to 9.
  - state <= IDLE; done=0 that cycle.
- start:
  - IDLE or PAUSE with zero=0 -> RUN on the next edge. The tick in the same cycle is ignored.
  - start with zero=1 is ignored: no busy, no done.
  - start in RUN or DONE: no effect.
- stop:
  - RUN -> PAUSE; q holds and a coincident tick is ignored.
  - stop in any other state: no effect.
- Decrement (RUN and tick=1):
  - Digit i decrements iff all lower digits are 0. Digit 0 always decrements.
  - A digit at 0 wraps to 9 (borrow). Example: 1000 -> 0999.
  - Latency: q updates on the same edge that samples tick.
- Terminal count: RUN, tick=1 and q==1 (value one).
  - q <= 0 and state <= DONE.
  - done=1 in exactly the cycle in which q first reads 0.
  - DONE -> IDLE on the next edge unconditionally; done returns to 0.
- q never underflows: RUN is never entered with q=0, so the counter cannot pass from 0 to 99..9.
- PAUSE: q holds and tick is ignored; start -> RUN.
- Asynchronous rst mid-count: everything returns to reset values immediately; any done pulse in progress is cancelled.

Optional Feature:
- Macro: BCD_TIMER_AUTO_RELOAD_EN.
- Defined:
  - At terminal count, if the preset register is nonzero, q <= preset instead of 0.
  - done pulses for one cycle and the state stays RUN (periodic timer); q never reads 0 in this mode.
  - If the preset is 0, behaviour is as without the macro.
- Undefined: preset register is still loaded, but only the one-shot behaviour above applies.

Decomposition:
- Shared package/header bcd_pkg: state encodings ST_IDLE/ST_RUN/ST_PAUSE/ST_DONE, BCD_MAX=4'd9, BCD_W=4.
- Sub-module bcd_down_digit, instantiated NDIG times in a generate loop:
  - Ports: clk, rst, en, ld, d, q, is_zero.
  - Clamps d on ld; decrements with 0->9 wrap when en.
  - The top level builds each digit's en as active_tick AND the is_zero outputs of all lower digits.

Test Plan:
1. Assert rst mid-count with q=0457 -> q=0000, busy=0, done=0, zero=1 immediately, without waiting for a clock edge.
2. load 0x0103, start, 103 ticks spaced 3 cycles apart -> sequence 0102, 0101, 0100, 0099, ... 0001, 0000. done=1 exactly one cycle at 0000; busy falls the same cycle; IDLE one cycle later.
3. load 0x1000, start, one tick -> q=0999. A further tick -> 0998.
4. RUN at 0050, stop and tick in the same cycle -> q stays 0050, busy=0. Tick while paused -> no change. start, then tick -> 0049.
5. load 0x00A5 -> q=0x0095 (digit clamped). load 0x0000, then start -> busy stays 0, done stays 0.
6. With BCD_TIMER_AUTO_RELOAD_EN: load 0002, start, 4 ticks -> 0001, 0002 (done pulse), 0001, 0002 (done pulse); busy stays 1 throughout.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD countdown timer: state encoding, digit width and clamp helper.
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown chain: clamped parallel load, decrement with 0->9 borrow wrap.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q,
  output logic             is_zero
);

  logic [BCD_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = bcd_clamp(d);
    end else if (en) begin
      q_d = (q_q == 4'd0) ? BCD_MAX : (q_q - 4'd1);
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q       = q_q;
  assign is_zero = (q_q == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with load/start/stop and a one-cycle done pulse.
// Define BCD_TIMER_AUTO_RELOAD_EN to reload the preset at terminal count (periodic mode).
module bcd_down_timer
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  load,
  input  logic [4*NDIG-1:0]     load_val,
  input  logic                  start,
  input  logic                  stop,
  output logic [4*NDIG-1:0]     q,
  output logic                  busy,
  output logic                  zero,
  output logic                  done
);

  localparam int QW = BCD_W * NDIG;

  state_e          state_q, state_d;
  logic [QW-1:0]   preset_q, preset_d;
  logic            done_q, done_d;

  logic [QW-1:0]   load_clamped;
  logic [QW-1:0]   dig_d;
  logic [NDIG-1:0] dig_zero;
  logic [NDIG:0]   lower_zero;
  logic            dig_ld;
  logic            active_tick;
  logic            term_tick;
  logic            reload;

  // A tick only counts in RUN when neither load nor stop claims the cycle.
  assign active_tick = (state_q == ST_RUN) & tick & ~load & ~stop;
  assign term_tick   = active_tick & (q == QW'(1));

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  assign reload = term_tick & (preset_q != '0);
`else
  assign reload = 1'b0;
`endif

  assign dig_ld        = load | reload;
  assign dig_d         = load ? load_val : preset_q;
  assign lower_zero[0] = 1'b1;

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    assign lower_zero[i+1]                  = lower_zero[i] & dig_zero[i];
    assign load_clamped[i*BCD_W +: BCD_W]   = bcd_clamp(load_val[i*BCD_W +: BCD_W]);

    bcd_down_digit u_digit (
      .clk     (clk),
      .rst     (rst),
      .en      (active_tick & lower_zero[i]),
      .ld      (dig_ld),
      .d       (dig_d[i*BCD_W +: BCD_W]),
      .q       (q[i*BCD_W +: BCD_W]),
      .is_zero (dig_zero[i])
    );
  end

  assign zero = lower_zero[NDIG];
  assign busy = (state_q == ST_RUN);
  assign done = done_q;

  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    done_d   = 1'b0;
    if (load) begin
      state_d  = ST_IDLE;
      preset_d = load_clamped;
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSE: begin
          if (start && !zero) state_d = ST_RUN;
          else                state_d = state_q;
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (term_tick) begin
            done_d  = 1'b1;
            state_d = reload ? ST_RUN : ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      preset_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      done_q   <= done_d;
    end
  end

endmodule
